alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
//  Downstream of the ALU. Captures each ALU result with its ZF/CF/NF/OF flags and updates the architectural status register.
//  Queues register-file writes in a small FIFO and drains them through a write port that can stall (wr_ack).
//  Exports a per-register pending-write mask so the issue stage can stall on RAW hazards.
// PARAMETERS
//  DEPTH       4   write FIFO entries (power of 2, >=2)
//  NUM_REGS    8   architectural registers
//  REG_AW      3   register address width, clog2(NUM_REGS)
// PORTS
//  clk          in   1        clock, all state on posedge
//  rst          in   1        synchronous reset, active-high
//  in_valid     in   1        ALU result valid this cycle
//  in_ready     out  1        stage can accept (combinational from count)
//  in_opcode    in   6        opcode the ALU executed
//  in_dst       in   REG_AW   destination register
//  in_result    in   17       ALU result; bit 16 = carry-out
//  in_flags     in   4        {OF,NF,CF,ZF} from ALU
//  wr_en        out  1        register-file write request (FIFO head valid)
//  wr_addr      out  REG_AW   head destination
//  wr_data      out  16       head data
//  wr_ack       in   1        regfile accepted head this cycle
//  flags_q      out  4        status register {OF,NF,CF,ZF}
//  busy_mask    out  NUM_REGS bit r=1 while any queued write targets r
//  fifo_count   out  clog2(DEPTH+1)  entries held
//  err_illegal  out  1        one-cycle pulse: illegal opcode accepted
// BEHAVIOUR
//  - Reset: FIFO empty, fifo_count=0, flags_q=0, busy_mask=0, wr_en=0, err_illegal=0. Reset mid-drain discards all queued writes.
//  - Accept = in_valid & in_ready; in_ready = (fifo_count < DEPTH). No same-cycle pass-through when full.
//  - Opcode classes (legal range 0x09..0x1A):
//      CMP 0x17      : flags update only, no write.
//      MOV 0x0F      : write only, flags_q unchanged.
//      all other legal: write + flags update.
//      outside range : no write, no flags update, err_illegal=1 next cycle.
//  - Flags: flags_q <= in_flags on the edge of acceptance; visible the following cycle.
//  - Write data = in_result[15:0]; bit 16 is dropped (carry reaches software only via CF).
//  - FIFO: push {in_dst, in_result[15:0]} on acceptance. wr_en = (count != 0), wr_addr/wr_data = head.
//    Pop on wr_en & wr_ack. Minimum latency accept->wr_en = 1 cycle. Writes drain strictly in order.
//  - Simultaneous push+pop: count unchanged, both take effect; legal at any count < DEPTH.
//  - wr_ack while wr_en=0 is ignored.
//  - Pointers wrap modulo DEPTH.
//  - busy_mask: per-register pending counter, width clog2(DEPTH+1). +1 on push to r, -1 on pop from r.
//    Push and pop to the same r in one cycle leaves it unchanged. Bit = (counter != 0), registered, updates same edge as FIFO.
//  - Illegal or CMP accepts consume no FIFO slot but still require in_ready=1.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_ADD..OP_DEC, OP_MOV, OP_CMP, OP_MIN/OP_MAX), flag bit indices FLAG_ZF=0, CF=1, NF=2, OF=3.
//    Shared with ALU_unit and decode.
//  - Sub-module wb_sync_fifo (DEPTH x (REG_AW+16), push/pop/count/full/empty). Opcode classing and busy counters stay in the top.
// TESTING
//  1. Reset then ADD(0x09) dst=3 result=17'h1_0005 flags=4'b0010 -> next cycle wr_en=1, addr=3, data=0005;
//     flags_q=0010; busy_mask=0000_1000.
//  2. wr_ack held 0, push 4 writes -> fifo_count=4, in_ready=0; a 5th in_valid is not accepted.
//     Assert wr_ack: drains in order, one per cycle.
//  3. CMP(0x17) flags=4'b0100 -> flags_q=0100, fifo_count unchanged, no wr_en.
//     MOV(0x0F) -> write queued, flags_q stays 0100.
//  4. Opcode 0x3F -> err_illegal pulses 1 cycle, no write, flags_q unchanged.
//  5. Two queued writes to r2, then push r2 while popping r2 -> busy_mask[2] stays 1.
//     After final pop, busy_mask[2]=0 the following cycle.
//  6. rst asserted with 3 entries pending -> next cycle wr_en=0, fifo_count=0, busy_mask=0, flags_q=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode map and status-flag bit positions shared by the ALU, decode and writeback stage.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'h09;
  localparam logic [5:0] OP_SUB = 6'h0A;
  localparam logic [5:0] OP_AND = 6'h0B;
  localparam logic [5:0] OP_OR  = 6'h0C;
  localparam logic [5:0] OP_XOR = 6'h0D;
  localparam logic [5:0] OP_NOT = 6'h0E;
  localparam logic [5:0] OP_MOV = 6'h0F;
  localparam logic [5:0] OP_SHL = 6'h10;
  localparam logic [5:0] OP_SHR = 6'h11;
  localparam logic [5:0] OP_ROL = 6'h12;
  localparam logic [5:0] OP_ROR = 6'h13;
  localparam logic [5:0] OP_ADC = 6'h14;
  localparam logic [5:0] OP_SBB = 6'h15;
  localparam logic [5:0] OP_INC = 6'h16;
  localparam logic [5:0] OP_CMP = 6'h17;
  localparam logic [5:0] OP_DEC = 6'h18;
  localparam logic [5:0] OP_MIN = 6'h19;
  localparam logic [5:0] OP_MAX = 6'h1A;

  localparam logic [5:0] OP_LEGAL_LO = OP_ADD;
  localparam logic [5:0] OP_LEGAL_HI = OP_MAX;

  localparam int FLAG_ZF = 0;
  localparam int FLAG_CF = 1;
  localparam int FLAG_NF = 2;
  localparam int FLAG_OF = 3;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op >= OP_LEGAL_LO) && (op <= OP_LEGAL_HI);
  endfunction

endpackage

// File: rtl/wb_sync_fifo.sv
// In-order sync FIFO of pending register writes; data visible at head one cycle after push.
// Push is the caller's responsibility to gate on !full; pop on empty is ignored.
module wb_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback: latches flags, queues regfile writes, tracks per-register pending writes.
// Accept->wr_en 1 cycle; in_ready drops when the write FIFO is full, wr_ack stalls the drain.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [5:0]                   in_opcode,
  input  logic [REG_AW-1:0]            in_dst,
  input  logic [16:0]                  in_result,
  input  logic [3:0]                   in_flags,
  output logic                         wr_en,
  output logic [REG_AW-1:0]            wr_addr,
  output logic [15:0]                  wr_data,
  input  logic                         wr_ack,
  output logic [3:0]                   flags_q,
  output logic [NUM_REGS-1:0]          busy_mask,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         err_illegal
);

  localparam int CW = $clog2(DEPTH+1);

  logic              accept;
  logic              legal;
  logic              does_write;
  logic              does_flags;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              unused_carry;
  logic [CW-1:0]     busy_cnt [NUM_REGS];

  // Carry-out reaches software only through CF, never through the data path.
  assign unused_carry = in_result[16];

  assign legal      = op_is_legal(in_opcode);
  assign does_write = legal && (in_opcode != OP_CMP);
  assign does_flags = legal && (in_opcode != OP_MOV);
  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign push       = accept && does_write;
  assign wr_en      = !empty;
  assign pop        = wr_en && wr_ack;

  wb_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (REG_AW + 16)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_dst, in_result[15:0]}),
    .pop       (pop),
    .pop_data  ({wr_addr, wr_data}),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q     <= '0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= accept && !legal;
      if (accept && does_flags) flags_q <= in_flags;
    end
  end

  // Push and pop hitting the same register cancel out.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst) begin
        busy_cnt[r] <= '0;
      end else begin
        if ((push && in_dst == REG_AW'(r)) && !(pop && wr_addr == REG_AW'(r)))
          busy_cnt[r] <= busy_cnt[r] + CW'(1);
        else if (!(push && in_dst == REG_AW'(r)) && (pop && wr_addr == REG_AW'(r)))
          busy_cnt[r] <= busy_cnt[r] - CW'(1);
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = (busy_cnt[r] != '0);
  end

endmodule
